// File: rtl/arb_req_client.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : arb_req_client
//  Purpose  : Arbitrated bus master client. Buffers burst commands in a small
//             FIFO, requests the bus, emits cmd_len+1 incrementing data beats
//             while granted, and flags protocol errors (stray / lost grant).
//  Revision : 1.0  initial release
// ============================================================================
module arb_req_client #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 4,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic              req,
   input  logic              gnt,
   output logic              bus_valid,
   output logic [DATA_W-1:0] bus_data,
   output logic              bus_last,
   input  logic              err_clr,
   output logic              err_unreq,
   output logic              err_drop
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int ENT_W = DATA_W + LEN_W;

   // DEPTH must be a power of two so the pointers wrap naturally.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("arb_req_client: DEPTH must be a power of two >= 2");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_XFER = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic [ENT_W-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic               emit;
   logic               drop;
   logic [LEN_W-1:0]   beat_cnt;
   logic [ENT_W-1:0]   head;
   logic [DATA_W-1:0]  head_data;
   logic [LEN_W-1:0]   head_len;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign cmd_ready = ~full;
   // Push is gated by full alone; a pop in the same cycle does not free a slot.
   assign push      = cmd_valid & ~full;
   assign head      = mem[rd_ptr];
   assign head_data = head[ENT_W-1:LEN_W];
   assign head_len  = head[LEN_W-1:0];

   // Command storage; contents need no reset because occupancy gates use.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {cmd_data, cmd_len};
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus beat-emit / pop / grant-drop decisions. A beat is
   // launched on the edge that samples the grant, so the first beat shows up
   // the cycle after gnt is seen in REQ; the burst retires on the edge after
   // the last beat has been presented.
   always_comb begin
      state_nxt = state;
      emit      = 1'b0;
      pop       = 1'b0;
      drop      = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty) state_nxt = S_REQ;
         end
         S_REQ: begin
            if (gnt) begin
               emit      = 1'b1;
               state_nxt = S_XFER;
            end
         end
         S_XFER: begin
            if (bus_last) begin
               pop       = 1'b1;
               state_nxt = S_GAP;
            end else if (gnt) begin
               emit = 1'b1;
            end else begin
               drop = 1'b1;
            end
         end
         S_GAP: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Registered bus outputs, beat counter and sticky error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req       <= 1'b0;
         bus_valid <= 1'b0;
         bus_data  <= '0;
         bus_last  <= 1'b0;
         beat_cnt  <= '0;
         err_unreq <= 1'b0;
         err_drop  <= 1'b0;
      end else begin
         req <= (state_nxt == S_REQ) || (state_nxt == S_XFER);
         if (emit) begin
            bus_valid <= 1'b1;
            bus_data  <= head_data + DATA_W'(beat_cnt);
            bus_last  <= (beat_cnt == head_len);
            beat_cnt  <= beat_cnt + LEN_W'(1);
         end else begin
            bus_valid <= 1'b0;
            bus_data  <= '0;
            bus_last  <= 1'b0;
            if (pop) beat_cnt <= '0;
         end
         // A new error in the clearing cycle keeps the flag set.
         err_unreq <= (gnt & ~req) | (err_unreq & ~err_clr);
         err_drop  <= drop | (err_drop & ~err_clr);
      end
   end

   // Protocol sanity checks.
   always @(posedge clk) begin
      if (rst_n) begin
         assert (!bus_last || bus_valid);
         assert (!bus_valid || req);
         assert (!(push && full));
         assert (!(pop && empty));
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_arb_req_client.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_arb_req_client
//  Purpose  : Scoreboard testbench for arb_req_client. Accepted commands are
//             expanded into expected beats; a monitor compares every beat.
//  Revision : 1.0  initial release
// ============================================================================
module tb_arb_req_client;

   localparam int DATA_W = 32;
   localparam int LEN_W  = 4;
   localparam int DEPTH  = 4;

   logic              clk       = 1'b0;
   logic              rst_n     = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [DATA_W-1:0] cmd_data  = '0;
   logic [LEN_W-1:0]  cmd_len   = '0;
   logic              req;
   logic              gnt       = 1'b0;
   logic              bus_valid;
   logic [DATA_W-1:0] bus_data;
   logic              bus_last;
   logic              err_clr   = 1'b0;
   logic              err_unreq;
   logic              err_drop;

   arb_req_client #(.DATA_W(DATA_W), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_data  (cmd_data),
      .cmd_len   (cmd_len),
      .req       (req),
      .gnt       (gnt),
      .bus_valid (bus_valid),
      .bus_data  (bus_data),
      .bus_last  (bus_last),
      .err_clr   (err_clr),
      .err_unreq (err_unreq),
      .err_drop  (err_drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              last;
   } beat_t;

   beat_t expq[$];
   int    pending  = 0;
   bit    pop_next = 1'b0;
   bit    prev_last = 1'b0;
   int    total = 0;
   int    bad   = 0;

   function automatic void check(input string name, input logic [DATA_W-1:0] act,
                                 input logic [DATA_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Reference model: an accepted command becomes len+1 beats of base+i,
   // the final one marked last. A command slot frees on the edge after its
   // last beat is observed; a full queue refuses pushes even on that edge.
   always @(posedge clk) begin
      beat_t nb;
      if (rst_n) begin
         if (cmd_valid && pending < DEPTH) begin
            for (int i = 0; i <= int'(cmd_len); i++) begin
               nb.data = cmd_data + DATA_W'(i);
               nb.last = (i == int'(cmd_len));
               expq.push_back(nb);
            end
            pending++;
         end
         if (pop_next) begin
            pending--;
            pop_next = 1'b0;
         end
      end
   end

   // Monitor: compares every presented beat and idle-cycle invariants.
   always @(negedge clk) begin
      beat_t b;
      if (rst_n) begin
         check("cmd_ready", {31'd0, cmd_ready}, {31'd0, (pending < DEPTH)});
         if (prev_last) check("gap_after_last", {31'd0, bus_valid}, 32'd0);
         if (bus_valid) begin
            check("req_with_valid", {31'd0, req}, 32'd1);
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got data %0h, required no beat (t=%0t)", bus_data, $time);
            end else begin
               b = expq.pop_front();
               check("beat_data", bus_data, b.data);
               check("beat_last", {31'd0, bus_last}, {31'd0, b.last});
               if (b.last) pop_next = 1'b1;
            end
         end else begin
            check("idle_data", bus_data, 32'd0);
            check("idle_last", {31'd0, bus_last}, 32'd0);
         end
         prev_last = bus_valid & bus_last;
      end else begin
         prev_last = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      expq.delete();
      pending   = 0;
      pop_next  = 1'b0;
      prev_last = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((expq.size() != 0 || pending != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (expq.size() != 0 || pending != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d beats outstanding, required 0", expq.size());
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_beat(input logic [DATA_W-1:0] target);
      int n = 0;
      @(negedge clk);
      while (!(bus_valid && bus_data == target) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!(bus_valid && bus_data == target)) begin
         total++;
         bad++;
         $display("FAIL wait_beat: got no beat %0h, required one", target);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},       {31'd0, req},       32'd0);
      check({tag, "_valid"},     {31'd0, bus_valid}, 32'd0);
      check({tag, "_last"},      {31'd0, bus_last},  32'd0);
      check({tag, "_data"},      bus_data,           32'd0);
      check({tag, "_err_unreq"}, {31'd0, err_unreq}, 32'd0);
      check({tag, "_err_drop"},  {31'd0, err_drop},  32'd0);
      check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit [6:0] exp_req;
      bit [6:0] exp_vld;
      int       post_beats;

      // Reset values.
      #12;
      check_reset_outputs("reset");
      step();
      rst_n = 1'b1;

      // Single 4-beat burst with grant held: cycle-exact shape.
      exp_req   = 7'b0111110;
      exp_vld   = 7'b0111100;
      cmd_valid = 1'b1;
      cmd_data  = 32'h100;
      cmd_len   = 4'd3;
      gnt       = 1'b1;
      step();
      cmd_valid = 1'b0;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         check("shape_req", {31'd0, req}, {31'd0, exp_req[k]});
         check("shape_valid", {31'd0, bus_valid}, {31'd0, exp_vld[k]});
         if (exp_vld[k]) check("shape_data", bus_data, 32'h100 + DATA_W'(k - 2));
      end
      gnt = 1'b0;

      // Stray grant handling and sticky clear.
      step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      @(negedge clk);
      check("unreq_cleared", {31'd0, err_unreq}, 32'd0);
      check("drop_none", {31'd0, err_drop}, 32'd0);
      gnt = 1'b1;
      step();
      gnt = 1'b0;
      @(negedge clk);
      check("unreq_set", {31'd0, err_unreq}, 32'd1);
      check("unreq_no_valid", {31'd0, bus_valid}, 32'd0);
      check("unreq_no_req", {31'd0, req}, 32'd0);
      gnt     = 1'b1;
      err_clr = 1'b1;
      step();
      gnt     = 1'b0;
      err_clr = 1'b0;
      @(negedge clk);
      check("unreq_new_wins", {31'd0, err_unreq}, 32'd1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      @(negedge clk);
      check("unreq_clear2", {31'd0, err_unreq}, 32'd0);

      // Data wraparound.
      cmd_valid = 1'b1;
      cmd_data  = 32'hFFFF_FFFF;
      cmd_len   = 4'd1;
      gnt       = 1'b1;
      step();
      cmd_valid = 1'b0;
      wait_beat(32'hFFFF_FFFF);
      @(negedge clk);
      check("wrap_data", bus_data, 32'h0);
      check("wrap_last", {31'd0, bus_last}, 32'd1);
      drain();
      gnt = 1'b0;

      // Fill past capacity with no grant, then release in order.
      for (int i = 0; i <= DEPTH; i++) begin
         cmd_valid = 1'b1;
         cmd_data  = 32'h1000 * DATA_W'(i + 1);
         cmd_len   = LEN_W'(i);
         step();
      end
      cmd_valid = 1'b0;
      @(negedge clk);
      check("full_ready", {31'd0, cmd_ready}, 32'd0);
      gnt = 1'b1;
      drain();
      gnt = 1'b0;

      // Grant lost mid-burst.
      err_clr = 1'b1;
      step();
      err_clr   = 1'b0;
      cmd_valid = 1'b1;
      cmd_data  = 32'h200;
      cmd_len   = 4'd3;
      gnt       = 1'b1;
      step();
      cmd_valid = 1'b0;
      wait_beat(32'h201);
      gnt = 1'b0;
      @(negedge clk);
      check("drop_gap1", {31'd0, bus_valid}, 32'd0);
      check("drop_flag", {31'd0, err_drop}, 32'd1);
      @(negedge clk);
      check("drop_gap2", {31'd0, bus_valid}, 32'd0);
      gnt = 1'b1;
      @(negedge clk);
      check("drop_resume_valid", {31'd0, bus_valid}, 32'd1);
      check("drop_resume_data", bus_data, 32'h202);
      @(negedge clk);
      check("drop_final_data", bus_data, 32'h203);
      check("drop_final_last", {31'd0, bus_last}, 32'd1);
      drain();
      gnt = 1'b0;
      @(negedge clk);
      check("drop_sticky", {31'd0, err_drop}, 32'd1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      @(negedge clk);
      check("drop_cleared", {31'd0, err_drop}, 32'd0);

      // Randomized traffic.
      repeat (400) begin
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_data  = $urandom;
         cmd_len   = LEN_W'($urandom_range(0, 15));
         gnt       = ($urandom_range(0, 3) != 0);
         err_clr   = ($urandom_range(0, 7) == 0);
         step();
      end
      cmd_valid = 1'b0;
      err_clr   = 1'b0;
      gnt       = 1'b1;
      drain();

      // Reset in the middle of a burst with more work queued.
      cmd_valid = 1'b1;
      cmd_data  = 32'h300;
      cmd_len   = 4'd3;
      step();
      cmd_data  = 32'h400;
      cmd_len   = 4'd2;
      step();
      cmd_valid = 1'b0;
      wait_beat(32'h301);
      rst_n = 1'b0;
      clear_model();
      #1;
      check_reset_outputs("midreset");
      step();
      step();
      rst_n      = 1'b1;
      post_beats = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus_valid) post_beats++;
      end
      check("post_reset_beats", DATA_W'(post_beats), 32'd0);
      check("post_reset_ready", {31'd0, cmd_ready}, 32'd1);
      gnt = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
